// File: rtl/fpga_clk_div_multi_pkg.sv
// Shared types for the multi-channel clock/tick divider.
//   clkdiv_mode_e : channel output mode (TOGGLE = 50% clock, PULSE = 1-cycle strobe)
//   chan_state_e  : per-channel IDLE/RUN state
//   chan_cfg_t    : divisor + mode pair used for the shadow and current settings
//   min_div       : smallest legal divisor for a mode
//   clamp_cfg     : raises a divisor to the mode minimum when it becomes current
package fpga_clkdiv_pkg;

    // Wide enough for any CntWidth up to 32 so that D+1 never overflows.
    localparam int DivW = 33;

    typedef logic [DivW-1:0] clkdiv_div_t;

    typedef enum logic [0:0] {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } clkdiv_mode_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    typedef struct packed {
        clkdiv_div_t  div;
        clkdiv_mode_e mode;
    } chan_cfg_t;

    function automatic clkdiv_div_t min_div(input clkdiv_mode_e mode);
        clkdiv_div_t m;
        case (mode)
            TOGGLE:  m = clkdiv_div_t'(2'd2);
            PULSE:   m = clkdiv_div_t'(2'd1);
            default: m = clkdiv_div_t'(2'd2);
        endcase
        return m;
    endfunction

    function automatic chan_cfg_t clamp_cfg(input chan_cfg_t cfg);
        chan_cfg_t c;
        c = cfg;
        if (cfg.div < min_div(cfg.mode)) begin
            c.div = min_div(cfg.mode);
        end else begin
            c.div = cfg.div;
        end
        return c;
    endfunction

endpackage

// File: rtl/fpga_clk_div_multi_if.sv
// Control/status bundle of the clock divider.
//   en_i        : per-channel run enable
//   div_i       : requested divisor per channel
//   mode_i      : requested mode per channel (0 toggle, 1 pulse)
//   div_valid_i : one-cycle load strobe per channel
//   restart_i   : global phase-align strobe
//   clk_o       : divided clocks
//   tick_o      : period-start strobes
//   pending_o   : shadow update waiting for the period boundary
// master = controller side, slave = divider side.
interface fpga_clk_div_multi_if #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 16
);
    logic [NumChannels-1:0]               en_i;
    logic [NumChannels-1:0][CntWidth-1:0] div_i;
    logic [NumChannels-1:0]               mode_i;
    logic [NumChannels-1:0]               div_valid_i;
    logic                                 restart_i;
    logic [NumChannels-1:0]               clk_o;
    logic [NumChannels-1:0]               tick_o;
    logic [NumChannels-1:0]               pending_o;

    modport master (
        output en_i, div_i, mode_i, div_valid_i, restart_i,
        input  clk_o, tick_o, pending_o
    );

    modport slave (
        input  en_i, div_i, mode_i, div_valid_i, restart_i,
        output clk_o, tick_o, pending_o
    );
endinterface

// File: rtl/fpga_clk_div_multi_chan.sv
// One divider channel: period counter, shadow/current configuration and
// IDLE/RUN state machine. All outputs are registered.
//   soc_clk, rst_n : clock, async active-low reset
//   en_i           : run enable (level)
//   div_i, mode_i  : requested divisor/mode, captured on div_valid_i
//   restart_i      : forces a wrap on this edge when running
//   clk_o, tick_o  : divided clock and period-start strobe
//   pending_o      : a captured setting is waiting for the next wrap
module fpga_clk_div_chan
    import fpga_clkdiv_pkg::*;
#(
    parameter int CntWidth    = 16,
    parameter int DefaultDiv  = 50,
    parameter bit DefaultMode = 1'b0
) (
    input  logic                soc_clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [CntWidth-1:0] div_i,
    input  logic                mode_i,
    input  logic                div_valid_i,
    input  logic                restart_i,
    output logic                clk_o,
    output logic                tick_o,
    output logic                pending_o
);

    localparam chan_cfg_t RstCfg = '{div:  clkdiv_div_t'(DefaultDiv),
                                     mode: clkdiv_mode_e'(DefaultMode)};

    chan_state_e          state_r, state_s;
    logic [CntWidth-1:0]  cnt_r, cnt_s;
    chan_cfg_t            cur_r, cur_s;
    chan_cfg_t            shd_r, shd_s;
    logic                 clk_r, clk_s;
    logic                 tick_r, tick_s;
    logic                 pend_r, pend_s;

    chan_cfg_t            req_s;
    chan_cfg_t            nxt_shd_s;
    clkdiv_div_t          cnt_inc_s;
    clkdiv_div_t          half_s;
    logic                 wrap_s;

    // Request decode, shadow bypass and wrap/half-period arithmetic.
    always_comb begin
        req_s = '{div: clkdiv_div_t'(div_i), mode: clkdiv_mode_e'(mode_i)};
        // A load on the applying edge wins over the older shadow (bypass).
        if (div_valid_i) begin
            nxt_shd_s = req_s;
        end else begin
            nxt_shd_s = shd_r;
        end
        cnt_inc_s = clkdiv_div_t'(cnt_r) + clkdiv_div_t'(1'b1);
        half_s    = (cur_r.div + clkdiv_div_t'(1'b1)) >> 1'b1;
        // cnt == D-1 expressed as cnt+1 == D to avoid underflow.
        wrap_s    = (cnt_inc_s == cur_r.div) || restart_i;
    end

    // Next-state and next-output logic of the IDLE/RUN machine.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cur_s   = cur_r;
        shd_s   = nxt_shd_s;
        clk_s   = 1'b0;
        tick_s  = 1'b0;
        pend_s  = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (en_i) begin
                    state_s = ST_RUN;
                    cnt_s   = '0;
                    clk_s   = 1'b1;
                    tick_s  = 1'b1;
                    cur_s   = clamp_cfg(nxt_shd_s);
                    pend_s  = 1'b0;
                end else if (div_valid_i) begin
                    cur_s  = clamp_cfg(req_s);
                    pend_s = 1'b0;
                end else begin
                    cur_s = cur_r;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    if (div_valid_i) begin
                        pend_s = 1'b1;
                    end else begin
                        pend_s = pend_r;
                    end
                end else if (wrap_s) begin
                    cnt_s  = '0;
                    clk_s  = 1'b1;
                    tick_s = 1'b1;
                    cur_s  = clamp_cfg(nxt_shd_s);
                    pend_s = 1'b0;
                end else begin
                    cnt_s = CntWidth'(cnt_inc_s);
                    // High for the first ceil(D/2) counts; pulse mode follows tick (0 here).
                    if (cur_r.mode == TOGGLE) begin
                        clk_s = (cnt_inc_s < half_s);
                    end else begin
                        clk_s = 1'b0;
                    end
                    if (div_valid_i) begin
                        pend_s = 1'b1;
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                pend_s  = 1'b0;
            end
        endcase
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            cur_r   <= clamp_cfg(RstCfg);
            shd_r   <= RstCfg;
            clk_r   <= 1'b0;
            tick_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cur_r   <= cur_s;
            shd_r   <= shd_s;
            clk_r   <= clk_s;
            tick_r  <= tick_s;
            pend_r  <= pend_s;
        end
    end

    assign clk_o     = clk_r;
    assign tick_o    = tick_r;
    assign pending_o = pend_r;

endmodule

// File: rtl/fpga_clk_div_multi.sv
// Multi-channel clock/tick divider top level. Instantiates NumChannels
// independent channels and fans the global restart out to all of them.
//   soc_clk, rst_n : clock, async active-low reset
//   bus (slave)    : per-channel enable/divisor/mode/load, global restart,
//                    divided clocks, ticks and pending flags
module fpga_clk_div_multi
    import fpga_clkdiv_pkg::*;
#(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 16,
    parameter int DefaultDiv  = 50,
    parameter bit DefaultMode = 1'b0
) (
    input  logic                  soc_clk,
    input  logic                  rst_n,
    fpga_clk_div_multi_if.slave   bus
);

    logic [NumChannels-1:0] clk_s;
    logic [NumChannels-1:0] tick_s;
    logic [NumChannels-1:0] pend_s;

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        fpga_clk_div_chan #(
            .CntWidth    (CntWidth),
            .DefaultDiv  (DefaultDiv),
            .DefaultMode (DefaultMode)
        ) u_chan (
            .soc_clk     (soc_clk),
            .rst_n       (rst_n),
            .en_i        (bus.en_i[g]),
            .div_i       (bus.div_i[g]),
            .mode_i      (bus.mode_i[g]),
            .div_valid_i (bus.div_valid_i[g]),
            .restart_i   (bus.restart_i),
            .clk_o       (clk_s[g]),
            .tick_o      (tick_s[g]),
            .pending_o   (pend_s[g])
        );
    end

    assign bus.clk_o     = clk_s;
    assign bus.tick_o    = tick_s;
    assign bus.pending_o = pend_s;

endmodule

// File: tb/tb_fpga_clk_div_multi.sv
// Directed bench for fpga_clk_div_multi with a queue scoreboard: expected
// per-channel {clk, tick, pending} values are queued when inputs are driven
// and checked #1 after the following clock edge.
module tb_fpga_clk_div_multi;

    localparam int NCh = 3;
    localparam int CW  = 16;

    logic soc_clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef struct {
        string      tag;
        int         ch;
        logic [2:0] exp;
        logic [2:0] mask;
    } sb_t;

    sb_t sb_q[$];

    fpga_clk_div_multi_if #(.NumChannels(NCh), .CntWidth(CW)) bus ();

    fpga_clk_div_multi #(
        .NumChannels (NCh),
        .CntWidth    (CW),
        .DefaultDiv  (50),
        .DefaultMode (1'b0)
    ) dut (
        .soc_clk (soc_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic expect_ch(input string tag, input int ch, input logic c,
                             input logic t, input logic p);
        sb_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.exp  = {c, t, p};
        e.mask = 3'b111;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t        e;
        logic [2:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = {bus.clk_o[e.ch], bus.tick_o[e.ch], bus.pending_o[e.ch]} & e.mask;
            n_cmp++;
            assert (obs === (e.exp & e.mask)) else begin
                n_fail++;
                $error("FAIL %s ch%0d: clk/tick/pend observed %b expected %b",
                       e.tag, e.ch, obs, e.exp & e.mask);
            end
        end
    endtask

    task automatic cycle();
        @(posedge soc_clk);
        #1;
        drain();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.en_i        = '0;
        bus.div_i       = '0;
        bus.mode_i      = '0;
        bus.div_valid_i = '0;
        bus.restart_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge soc_clk);
        #1;
        for (int c = 0; c < NCh; c++) expect_ch("reset", c, 1'b0, 1'b0, 1'b0);
        drain();

        // Default divisor 50, toggle, first tick on the enable edge
        rst_n       = 1'b1;
        bus.en_i[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            expect_ch("div50", 0, (k % 50) < 25, (k % 50) == 0, 1'b0);
            expect_ch("idle1", 1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        bus.en_i[0] = 1'b0;
        expect_ch("stop0", 0, 1'b0, 1'b0, 1'b0);
        cycle();

        // Ch1 pulse mode, divisor 3 loaded while idle
        bus.div_i[1] = 16'd3; bus.mode_i[1] = 1'b1; bus.div_valid_i[1] = 1'b1;
        expect_ch("ld_idle", 1, 1'b0, 1'b0, 1'b0);
        cycle();
        bus.div_valid_i[1] = 1'b0;
        bus.en_i[1]        = 1'b1;
        for (int k = 0; k < 9; k++) begin
            expect_ch("pulse3", 1, (k % 3) == 0, (k % 3) == 0, 1'b0);
            cycle();
        end
        bus.en_i[1] = 1'b0;
        expect_ch("stop1", 1, 1'b0, 1'b0, 1'b0);
        cycle();

        // Pulse divisor 0 clamps to 1: constantly high
        bus.div_i[1] = 16'd0; bus.div_valid_i[1] = 1'b1;
        expect_ch("ld_p0", 1, 1'b0, 1'b0, 1'b0);
        cycle();
        bus.div_valid_i[1] = 1'b0;
        bus.en_i[1]        = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_ch("pulse0", 1, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        bus.en_i[1] = 1'b0;
        expect_ch("stop1b", 1, 1'b0, 1'b0, 1'b0);
        cycle();

        // Ch0 divisor 8, new divisor 4 loaded mid-period stays pending until wrap
        bus.div_i[0] = 16'd8; bus.mode_i[0] = 1'b0; bus.div_valid_i[0] = 1'b1;
        expect_ch("ld8", 0, 1'b0, 1'b0, 1'b0);
        cycle();
        bus.div_valid_i[0] = 1'b0;
        bus.en_i[0]        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_ch("div8", 0, k < 4, k == 0, 1'b0);
            cycle();
        end
        bus.div_i[0] = 16'd4; bus.div_valid_i[0] = 1'b1;
        expect_ch("pend_set", 0, 1'b1, 1'b0, 1'b1);
        cycle();
        bus.div_valid_i[0] = 1'b0;
        for (int k = 4; k < 8; k++) begin
            expect_ch("pend_hold", 0, k < 4, 1'b0, 1'b1);
            cycle();
        end
        for (int m = 0; m < 8; m++) begin
            expect_ch("div4", 0, (m % 4) < 2, (m % 4) == 0, 1'b0);
            cycle();
        end

        // Load coincident with the wrap edge: bypass, no pending
        bus.div_i[0] = 16'd6; bus.div_valid_i[0] = 1'b1;
        for (int m = 0; m < 12; m++) begin
            expect_ch("bypass6", 0, (m % 6) < 3, (m % 6) == 0, 1'b0);
            cycle();
            bus.div_valid_i[0] = 1'b0;
        end
        // Toggle divisor 1 clamps to 2
        bus.div_i[0] = 16'd1; bus.div_valid_i[0] = 1'b1;
        for (int m = 0; m < 6; m++) begin
            expect_ch("tog1", 0, (m % 2) == 0, (m % 2) == 0, 1'b0);
            cycle();
            bus.div_valid_i[0] = 1'b0;
        end

        // Restart phase-aligns ch0 (div 6) and ch1 (div 10); ch2 stays idle
        bus.en_i[0] = 1'b0;
        expect_ch("stop0b", 0, 1'b0, 1'b0, 1'b0);
        cycle();
        bus.div_i[0] = 16'd6;  bus.mode_i[0] = 1'b0;
        bus.div_i[1] = 16'd10; bus.mode_i[1] = 1'b0;
        bus.div_valid_i = 3'b011;
        expect_ch("ld_pair0", 0, 1'b0, 1'b0, 1'b0);
        expect_ch("ld_pair1", 1, 1'b0, 1'b0, 1'b0);
        cycle();
        bus.div_valid_i = 3'b000;
        bus.en_i[0]     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_ch("pre0", 0, (k % 6) < 3, (k % 6) == 0, 1'b0);
            expect_ch("pre1", 1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        bus.en_i[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            expect_ch("pre0", 0, ((3 + j) % 6) < 3, ((3 + j) % 6) == 0, 1'b0);
            expect_ch("pre1", 1, (j % 10) < 5, (j % 10) == 0, 1'b0);
            cycle();
        end
        bus.restart_i = 1'b1;
        for (int r = 0; r < 16; r++) begin
            expect_ch("rst_ch0", 0, (r % 6) < 3, (r % 6) == 0, 1'b0);
            expect_ch("rst_ch1", 1, (r % 10) < 5, (r % 10) == 0, 1'b0);
            expect_ch("rst_ch2", 2, 1'b0, 1'b0, 1'b0);
            cycle();
            bus.restart_i = 1'b0;
        end

        // Drop enable at cnt=3, idle 5 cycles, re-enable from cnt=0 with tick
        bus.en_i = 3'b000;
        for (int i = 0; i < 5; i++) begin
            expect_ch("idle0", 0, 1'b0, 1'b0, 1'b0);
            expect_ch("idle1b", 1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        bus.en_i[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            expect_ch("reen", 0, (k % 6) < 3, (k % 6) == 0, 1'b0);
            cycle();
        end

        // Asynchronous reset mid-period, then divisor back to 50
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCh; c++) expect_ch("async_rst", c, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n = 1'b1;
        for (int k = 0; k < 51; k++) begin
            expect_ch("post_rst50", 0, (k % 50) < 25, (k % 50) == 0, 1'b0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
